// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: one requester's channel pair into the shared-ALU arbiter.
// The request channel carries operands and a 2-bit ALU select under valid/ready.
// The response channel returns the result and flags under valid/ready.
interface alu_arbiter_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic [1:0]  req_sel;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_out;
   logic        rsp_zero;
   logic        rsp_ovf;
   logic        rsp_gez;

   // Requester side: issues operations and accepts results.
   modport master (
      output req_valid, req_a, req_b, req_sel, rsp_ready,
      input  req_ready, rsp_valid, rsp_out, rsp_zero, rsp_ovf, rsp_gez
   );

   // Arbiter side: accepts operations and returns results.
   modport slave (
      input  req_valid, req_a, req_b, req_sel, rsp_ready,
      output req_ready, rsp_valid, rsp_out, rsp_zero, rsp_ovf, rsp_gez
   );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sequencer that shares one 32-bit ALU between two
// requesters. One operation is in flight at a time: IDLE grants a port, EXEC
// drives the ALU from registered operands and captures its outputs, and RESP
// holds the result until the owning port accepts it.
// Optional feature: define ALU_ARB_OVF_CNT_EN to build the saturating 8-bit
// overflow counter on ovf_count; otherwise ovf_count is tied to zero.
module alu_arbiter #(
   parameter bit RR_INIT = 1'b0   // port that wins the first simultaneous request
) (
   input  logic         clk,
   input  logic         rst_n,
   alu_arbiter_if.slave port0,
   alu_arbiter_if.slave port1,
   output logic [31:0]  alu_a,
   output logic [31:0]  alu_b,
   output logic [1:0]   alu_sel,
   input  logic [31:0]  alu_out,
   input  logic         alu_zero,
   input  logic         alu_overflow,
   input  logic         alu_ge,
   output logic [7:0]   ovf_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic        rr;          // port preferred on the next contended grant
   logic        owner;       // port that owns the operation in flight
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [1:0]  op_sel;
   logic [31:0] res_out;
   logic        res_zero;
   logic        res_ovf;
   logic        res_gez;
   logic        any_req;
   logic        grant;
   logic        accept;
   logic        rsp_ack;

   // Grant selection: a lone requester always wins, contention goes to rr.
   // Ready depends only on req_valid, rr and state, never on rsp_ready.
   always_comb begin
      any_req = port0.req_valid | port1.req_valid;
      if (port0.req_valid && port1.req_valid)
         grant = rr;
      else
         grant = port1.req_valid;
      accept  = rst_n && (state == IDLE) && any_req;
      rsp_ack = owner ? port1.rsp_ready : port0.rsp_ready;
   end

   // Next-state logic for the IDLE -> EXEC -> RESP sequence.
   // NOTE: state_nxt is defaulted before the case so every path assigns it
   // and no latch is inferred.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (any_req) state_nxt = EXEC;
         EXEC:    state_nxt = RESP;
         RESP:    if (rsp_ack) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register; reset drops any in-flight operation.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Ownership and round-robin pointer, updated only on a grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner <= 1'b0;
         rr    <= RR_INIT;
      end else if (accept) begin
         owner <= grant;
         rr    <= ~grant;
      end
   end

   // Operand registers: loaded from the granted port, held otherwise so the
   // ALU inputs stay stable through EXEC and RESP.
   // NOTE: these datapath registers are reset because they are directly
   // visible on alu_a/alu_b/alu_sel and must read zero out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_a   <= '0;
         op_b   <= '0;
         op_sel <= '0;
      end else if (accept) begin
         op_a   <= grant ? port1.req_a   : port0.req_a;
         op_b   <= grant ? port1.req_b   : port0.req_b;
         op_sel <= grant ? port1.req_sel : port0.req_sel;
      end
   end

   // Result registers: capture the ALU outputs at the end of EXEC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_out  <= '0;
         res_zero <= 1'b0;
         res_ovf  <= 1'b0;
         res_gez  <= 1'b0;
      end else if (state == EXEC) begin
         res_out  <= alu_out;
         res_zero <= alu_zero;
         res_ovf  <= alu_overflow;
         res_gez  <= alu_ge;
      end
   end

`ifdef ALU_ARB_OVF_CNT_EN
   logic [7:0] ovf_cnt;

   // Saturating count of overflowing operations, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ovf_cnt <= '0;
      else if ((state == EXEC) && alu_overflow && (ovf_cnt != 8'hFF))
         ovf_cnt <= ovf_cnt + 8'd1;
   end

   assign ovf_count = ovf_cnt;
`else
   assign ovf_count = 8'd0;
`endif

   assign alu_a   = op_a;
   assign alu_b   = op_b;
   assign alu_sel = op_sel;

   assign port0.req_ready = accept && !grant;
   assign port1.req_ready = accept &&  grant;

   assign port0.rsp_valid = (state == RESP) && !owner;
   assign port1.rsp_valid = (state == RESP) &&  owner;

   // Both ports see the same result registers; rsp_valid tells them apart.
   assign port0.rsp_out  = res_out;
   assign port0.rsp_zero = res_zero;
   assign port0.rsp_ovf  = res_ovf;
   assign port0.rsp_gez  = res_gez;
   assign port1.rsp_out  = res_out;
   assign port1.rsp_zero = res_zero;
   assign port1.rsp_ovf  = res_ovf;
   assign port1.rsp_gez  = res_gez;

endmodule
